// File: rtl/eth_tx_framer.sv
// Ethernet transmit framer: turns a 32-bit word stream into a GMII byte stream.
// Each frame is sent as preamble/SFD, then the MAC header, then the payload
// padded to 46 bytes. Underrun and oversize frames are cut short with a tx_er byte.
// Define ETH_TX_FRAMER_FCS_EN to append the IEEE 802.3 CRC-32 FCS. Without it,
// the block contains no CRC logic.
module eth_tx_framer #(
    parameter logic [47:0] LOCAL_MAC  = 48'h02_00_C0_A8_00_01,
    parameter logic [47:0] REMOTE_MAC = 48'h02_00_C0_A8_00_02,
    parameter logic [15:0] ETHERTYPE  = 16'h0800,
    parameter int unsigned IFG_CYCLES = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        s_last,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en,
    output logic        gmii_tx_er,
    output logic        tx_busy,
    output logic        frame_done,
    output logic        frame_err
);

    // Handshake: a word moves on a rising edge where s_valid and s_ready are both 1.
    // s_ready is a function of state only. It is high on the last header byte, on
    // the 4th byte of a non-final payload word, and throughout DROP. If s_valid is
    // low at such a point (outside DROP), that is an underrun.

    typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, PAYLOAD, PAD, FCS, DROP, IFG} state_t;

    localparam logic [111:0] HDR      = {REMOTE_MAC, LOCAL_MAC, ETHERTYPE};
    localparam logic [7:0]   IFG_LAST = 8'(IFG_CYCLES - 1);
    localparam logic [15:0]  MIN_LAST = 16'd45;   // payload count before the 46th byte
    localparam logic [15:0]  MAX_LAST = 16'd1499; // payload count before the 1500th byte

`ifdef ETH_TX_FRAMER_FCS_EN
    localparam state_t END_STATE = FCS;
    localparam logic   DATA_ENDS = 1'b0;
`else
    localparam state_t END_STATE = IFG;
    localparam logic   DATA_ENDS = 1'b1;
`endif

    state_t        state, state_nx;
    logic [7:0]    cnt;
    logic [1:0]    byte_idx;
    logic [15:0]   pay_cnt;
    logic [31:0]   word_q;
    logic          last_q;
    logic          err_slot;   // next PAYLOAD cycle is the tx_er byte
    logic          err_drop;   // after the tx_er byte, discard until s_last
    logic [7:0]    nx_txd;
    logic          nx_en, nx_er, nx_done, nx_err;
    logic          done_s1, err_s1;
    logic [111:0]  hdr_shift;
    logic [7:0]    pay_byte;
`ifdef ETH_TX_FRAMER_FCS_EN
    logic [31:0]   crc;
    logic [31:0]   fcs_word;
`endif

    assign tx_busy = (state != IDLE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (s_valid) state_nx = PREAMBLE;
            PREAMBLE: if (cnt == 8'd7) state_nx = HEADER;
            HEADER:   if (cnt == 8'd13) state_nx = PAYLOAD;
            PAYLOAD: begin
                if (err_slot)
                    state_nx = err_drop ? DROP : IFG;
                else if (byte_idx == 2'd3 && last_q)
                    state_nx = (pay_cnt < MIN_LAST) ? PAD : END_STATE;
            end
            PAD:      if (pay_cnt == MIN_LAST) state_nx = END_STATE;
            FCS:      if (cnt == 8'd3) state_nx = IFG;
            DROP:     if (s_valid && s_last) state_nx = IFG;
            IFG:      if (cnt == IFG_LAST) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Output logic: byte to register onto GMII next edge, handshake and end-of-frame flags
    always_comb begin
        nx_txd    = 8'h00;
        nx_en     = 1'b0;
        nx_er     = 1'b0;
        nx_done   = 1'b0;
        nx_err    = 1'b0;
        s_ready   = 1'b0;
        hdr_shift = HDR << {cnt, 3'b000};
        case (byte_idx)
            2'd0:    pay_byte = word_q[31:24];
            2'd1:    pay_byte = word_q[23:16];
            2'd2:    pay_byte = word_q[15:8];
            default: pay_byte = word_q[7:0];
        endcase
`ifdef ETH_TX_FRAMER_FCS_EN
        fcs_word = ~crc;
`endif
        case (state)
            IDLE: begin
                if (s_valid) begin
                    nx_en  = 1'b1;
                    nx_txd = 8'h55;
                end
            end
            PREAMBLE: begin
                nx_en  = 1'b1;
                nx_txd = (cnt == 8'd7) ? 8'hD5 : 8'h55;
            end
            HEADER: begin
                nx_en   = 1'b1;
                nx_txd  = hdr_shift[111:104];
                s_ready = (cnt == 8'd13);
            end
            PAYLOAD: begin
                nx_en = 1'b1;
                if (err_slot) begin
                    nx_er  = 1'b1;
                    nx_err = 1'b1;
                end else begin
                    nx_txd  = pay_byte;
                    s_ready = (byte_idx == 2'd3) && !last_q;
                    nx_done = DATA_ENDS && (byte_idx == 2'd3) && last_q && (pay_cnt >= MIN_LAST);
                end
            end
            PAD: begin
                nx_en   = 1'b1;
                nx_done = DATA_ENDS && (pay_cnt == MIN_LAST);
            end
`ifdef ETH_TX_FRAMER_FCS_EN
            FCS: begin
                nx_en   = 1'b1;
                nx_done = (cnt == 8'd3);
                case (cnt[1:0])
                    2'd0:    nx_txd = fcs_word[7:0];
                    2'd1:    nx_txd = fcs_word[15:8];
                    2'd2:    nx_txd = fcs_word[23:16];
                    default: nx_txd = fcs_word[31:24];
                endcase
            end
`endif
            DROP:    s_ready = 1'b1;
            default: ;
        endcase
    end

    // Counters, word holding register and error bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= 8'd0;
            byte_idx <= 2'd0;
            pay_cnt  <= 16'd0;
            word_q   <= 32'd0;
            last_q   <= 1'b0;
            err_slot <= 1'b0;
            err_drop <= 1'b0;
        end else begin
            // IDLE->PREAMBLE already put the first 0x55 out, so preamble counts from 1
            if (state_nx != state)
                cnt <= (state == IDLE) ? 8'd1 : 8'd0;
            else if (state == IDLE)
                cnt <= 8'd0;
            else
                cnt <= cnt + 8'd1;

            case (state)
                IDLE: begin
                    pay_cnt  <= 16'd0;
                    byte_idx <= 2'd0;
                    err_slot <= 1'b0;
                    err_drop <= 1'b0;
                end
                HEADER: begin
                    if (cnt == 8'd13) begin
                        if (s_valid) begin
                            word_q <= s_data;
                            last_q <= s_last;
                        end else begin
                            err_slot <= 1'b1;
                        end
                    end
                end
                PAYLOAD: begin
                    if (!err_slot) begin
                        pay_cnt  <= pay_cnt + 16'd1;
                        byte_idx <= byte_idx + 2'd1;
                        if (s_ready) begin
                            if (!s_valid) begin
                                err_slot <= 1'b1;
                            end else if (pay_cnt >= MAX_LAST) begin
                                // word would start byte 1501: consume it, flag error
                                err_slot <= 1'b1;
                                err_drop <= !s_last;
                            end else begin
                                word_q <= s_data;
                                last_q <= s_last;
                            end
                        end
                    end
                end
                PAD:     pay_cnt <= pay_cnt + 16'd1;
                default: ;
            endcase
        end
    end

    // GMII output registers and the two-stage pulse pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gmii_txd   <= 8'h00;
            gmii_tx_en <= 1'b0;
            gmii_tx_er <= 1'b0;
            done_s1    <= 1'b0;
            err_s1     <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            gmii_txd   <= nx_txd;
            gmii_tx_en <= nx_en;
            gmii_tx_er <= nx_er;
            done_s1    <= nx_done;
            err_s1     <= nx_err;
            frame_done <= done_s1;
            frame_err  <= err_s1;
        end
    end

`ifdef ETH_TX_FRAMER_FCS_EN
    // One byte of reflected CRC-32 (poly 0xEDB88320), data LSB first
    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // CRC accumulates every header, payload and pad byte; preset while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            crc <= 32'd0;
        else if (state == IDLE)
            crc <= 32'hFFFF_FFFF;
        else if (state == HEADER || state == PAD || (state == PAYLOAD && !err_slot))
            crc <= crc32_byte(crc, nx_txd);
    end
`endif

endmodule

// File: tb/tb_eth_tx_framer.sv
// Testbench for eth_tx_framer: table of frame sizes, random payloads, and
// hand-written underrun / oversize / back-to-back / mid-frame reset sequences.
// Follows ETH_TX_FRAMER_FCS_EN the same way the design does.
module tb_eth_tx_framer;

    localparam int IFG = 12;
`ifdef ETH_TX_FRAMER_FCS_EN
    localparam int FCS_LEN = 4;
`else
    localparam int FCS_LEN = 0;
`endif
    localparam logic [111:0] HDR = {48'h02_00_C0_A8_00_02, 48'h02_00_C0_A8_00_01, 16'h0800};

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_data = 32'd0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic [7:0]  gmii_txd;
    logic        gmii_tx_en, gmii_tx_er, tx_busy, frame_done, frame_err;

    eth_tx_framer dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .s_last(s_last), .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en),
        .gmii_tx_er(gmii_tx_er), .tx_busy(tx_busy), .frame_done(frame_done),
        .frame_err(frame_err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // per-cycle log: {busy, err, done, er, en, txd[7:0]}
    logic [12:0] log_q[$];
    bit          log_on = 1'b0;
    always @(negedge clk) if (log_on) log_q.push_back({tx_busy, frame_err, frame_done, gmii_tx_er, gmii_tx_en, gmii_txd});

    // stimulus stream and scoreboard
    logic [31:0] wd[$];
    bit          wl[$];
    logic [31:0] mw[$];
    logic [7:0]  exp_q[$];
    int          exp_len_q[$];
    logic [31:0] crc_tbl[256];

    // scan results
    int fr_start[$], fr_len[$], done_at[$], err_at[$];
    int er_cycles, txd_idle_bad, last_en, busy_low;

    // ---------------- reference model ----------------
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
        return crc_tbl[c[7:0] ^ b] ^ (c >> 8);
    endfunction

    // Expected bytes of one frame from mw[0..n-1]; good=0 means cut by a tx_er byte
    task automatic model_frame(input int n, input bit good);
        logic [7:0]   body[$];
        logic [111:0] h;
        logic [31:0]  w, c;
        int           pay;
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        h = HDR;
        for (int i = 0; i < 14; i++) begin
            body.push_back(h[111:104]);
            h = h << 8;
        end
        for (int i = 0; i < n; i++) begin
            w = mw[i];
            body.push_back(w[31:24]); body.push_back(w[23:16]);
            body.push_back(w[15:8]);  body.push_back(w[7:0]);
        end
        pay = 4 * n;
        if (good) while (pay < 46) begin body.push_back(8'h00); pay++; end
        foreach (body[i]) exp_q.push_back(body[i]);
        if (good) begin
`ifdef ETH_TX_FRAMER_FCS_EN
            c = 32'hFFFF_FFFF;
            foreach (body[i]) c = crc_step(c, body[i]);
            c = ~c;
            exp_q.push_back(c[7:0]);   exp_q.push_back(c[15:8]);
            exp_q.push_back(c[23:16]); exp_q.push_back(c[31:24]);
`endif
            exp_len_q.push_back(8 + body.size() + FCS_LEN);
        end else begin
            exp_q.push_back(8'h00);
            exp_len_q.push_back(8 + body.size() + 1);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_stream(input int budget);
        int guard = 0;
        while (wd.size() > 0 && guard < budget) begin
            s_data  = wd[0];
            s_last  = wl[0];
            s_valid = 1'b1;
            @(negedge clk);
            if (s_ready) begin
                @(posedge clk);
                #1;
                void'(wd.pop_front());
                void'(wl.pop_front());
            end
            guard++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 32'd0;
        check("drive_words_left", 64'(wd.size()), 0);
        wd.delete();
        wl.delete();
    endtask

    task automatic wait_idle(input int budget);
        int guard = 0;
        while (tx_busy && guard < budget) begin
            @(negedge clk);
            guard++;
        end
        check("wait_idle_timeout", 64'(tx_busy), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic start_test();
        log_q.delete(); exp_q.delete(); exp_len_q.delete(); mw.delete();
        log_on = 1'b1;
    endtask

    task automatic add_words(input int n, input bit last_on_end);
        logic [31:0] w;
        mw.delete();
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            mw.push_back(w);
            wd.push_back(w);
            wl.push_back(last_on_end && (i == n - 1));
        end
    endtask

    // ---------------- log analysis ----------------
    task automatic scan();
        logic [12:0] e, p;
        fr_start.delete(); fr_len.delete(); done_at.delete(); err_at.delete();
        er_cycles = 0; txd_idle_bad = 0; last_en = -1; busy_low = -1;
        p = 13'd0;
        for (int i = 0; i < log_q.size(); i++) begin
            e = log_q[i];
            if (e[8] && !p[8]) begin fr_start.push_back(i); fr_len.push_back(0); end
            if (e[8]) begin fr_len[fr_len.size() - 1] = fr_len[fr_len.size() - 1] + 1; last_en = i; end
            if (!e[8] && e[7:0] != 8'h00) txd_idle_bad++;
            if (e[9]) er_cycles++;
            if (e[10]) done_at.push_back(i);
            if (e[11]) err_at.push_back(i);
            p = e;
        end
        for (int i = last_en + 1; i < log_q.size() && last_en >= 0; i++) begin
            e = log_q[i];
            if (!e[12] && busy_low < 0) busy_low = i;
        end
    endtask

    function automatic int frame_bad(input int f, input int off);
        int          bad = 0;
        logic [12:0] e;
        for (int j = 0; j < fr_len[f]; j++) begin
            e = log_q[fr_start[f] + j];
            if (off + j >= exp_q.size()) bad++;
            else if (e[7:0] !== exp_q[off + j]) bad++;
        end
        return bad;
    endfunction

    function automatic logic [31:0] residue(input int f);
        logic [31:0] c = 32'hFFFF_FFFF;
        logic [12:0] e;
        for (int j = 8; j < fr_len[f]; j++) begin
            e = log_q[fr_start[f] + j];
            c = crc_step(c, e[7:0]);
        end
        return c;
    endfunction

    // Scoreboard for nf good frames held in exp_q / exp_len_q
    task automatic check_good(input string tag, input int nf);
        int off = 0;
        scan();
        check({tag, "_nframes"}, 64'(fr_start.size()), 64'(nf));
        check({tag, "_done_count"}, 64'(done_at.size()), 64'(nf));
        check({tag, "_err_count"}, 64'(err_at.size()), 0);
        check({tag, "_er_cycles"}, 64'(er_cycles), 0);
        check({tag, "_txd_when_idle"}, 64'(txd_idle_bad), 0);
        if (fr_start.size() == nf && done_at.size() == nf) begin
            for (int f = 0; f < nf; f++) begin
                check({tag, "_len"}, 64'(fr_len[f]), 64'(exp_len_q[f]));
                check({tag, "_bad_bytes"}, 64'(frame_bad(f, off)), 0);
                check({tag, "_done_pos"}, 64'(done_at[f]), 64'(fr_start[f] + fr_len[f]));
`ifdef ETH_TX_FRAMER_FCS_EN
                check({tag, "_fcs_residue"}, 64'(residue(f)), 64'h0000_0000_DEBB_20E3);
`endif
                if (f > 0) check({tag, "_ifg_gap"}, 64'(fr_start[f] - fr_start[f-1] - fr_len[f-1]), 64'(IFG));
                off += exp_len_q[f];
            end
            check({tag, "_busy_tail"}, 64'(busy_low - last_en), 64'(IFG));
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int n_words;
        int base_len;   // tx_en cycles excluding FCS
    } vec_t;
    vec_t vec[6];

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] c;
        int          n;
        logic [12:0] e;

        vec[0] = '{1, 68};    // 4 payload + 42 pad
        vec[1] = '{2, 68};
        vec[2] = '{3, 68};
        vec[3] = '{11, 68};   // 44 payload + 2 pad
        vec[4] = '{12, 70};   // 48 payload, no pad
        vec[5] = '{20, 102};

        for (int v = 0; v < 256; v++) begin
            c = 32'(v);
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tbl[v] = c;
        end

        // reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", {gmii_txd, gmii_tx_en, gmii_tx_er, s_ready, tx_busy, frame_done, frame_err}, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_busy", 64'(tx_busy), 0);

        // table-driven frame sizes with random payload
        for (int t = 0; t < 6; t++) begin
            start_test();
            add_words(vec[t].n_words, 1'b1);
            model_frame(vec[t].n_words, 1'b1);
            drive_stream(2000);
            wait_idle(2000);
            log_on = 1'b0;
            check_good("vec", 1);
            if (fr_len.size() == 1) check("vec_table_len", 64'(fr_len[0]), 64'(vec[t].base_len + FCS_LEN));
        end

        // fixed DEADBEEF frame
        start_test();
        mw.push_back(32'hDEADBEEF);
        wd.push_back(32'hDEADBEEF); wl.push_back(1'b1);
        model_frame(1, 1'b1);
        drive_stream(2000);
        wait_idle(2000);
        log_on = 1'b0;
        check_good("deadbeef", 1);
        if (fr_start.size() == 1) begin
            e = log_q[fr_start[0] + 22];
            check("deadbeef_first_payload", 64'(e[7:0]), 64'hDE);
        end

        // random sizes
        for (int r = 0; r < 4; r++) begin
            start_test();
            n = $urandom_range(1, 24);
            add_words(n, 1'b1);
            model_frame(n, 1'b1);
            drive_stream(2000);
            wait_idle(2000);
            log_on = 1'b0;
            check_good("rand", 1);
        end

        // two back-to-back 1-word frames with s_valid held
        start_test();
        add_words(1, 1'b1);
        model_frame(1, 1'b1);
        add_words(1, 1'b1);
        model_frame(1, 1'b1);
        drive_stream(2000);
        wait_idle(2000);
        log_on = 1'b0;
        check_good("b2b", 2);

        // underrun: 2 of 5 words, then s_valid drops
        start_test();
        add_words(2, 1'b0);
        model_frame(2, 1'b0);
        drive_stream(2000);
        wait_idle(2000);
        log_on = 1'b0;
        scan();
        check("underrun_nframes", 64'(fr_start.size()), 1);
        check("underrun_er_cycles", 64'(er_cycles), 1);
        check("underrun_err_count", 64'(err_at.size()), 1);
        check("underrun_done_count", 64'(done_at.size()), 0);
        if (fr_start.size() == 1 && err_at.size() == 1) begin
            check("underrun_len", 64'(fr_len[0]), 31);
            check("underrun_bad_bytes", 64'(frame_bad(0, 0)), 0);
            e = log_q[fr_start[0] + fr_len[0] - 1];
            check("underrun_last_er", 64'(e[9]), 1);
            check("underrun_err_pos", 64'(err_at[0]), 64'(fr_start[0] + fr_len[0]));
            check("underrun_busy_tail", 64'(busy_low - last_en), 64'(IFG));
        end

        // oversize: 380 words, error on byte slot 1501, rest dropped
        start_test();
        add_words(380, 1'b1);
        model_frame(375, 1'b0);
        drive_stream(5000);
        wait_idle(2000);
        log_on = 1'b0;
        scan();
        check("oversize_nframes", 64'(fr_start.size()), 1);
        check("oversize_er_cycles", 64'(er_cycles), 1);
        check("oversize_err_count", 64'(err_at.size()), 1);
        check("oversize_done_count", 64'(done_at.size()), 0);
        if (fr_start.size() == 1 && err_at.size() == 1) begin
            check("oversize_len", 64'(fr_len[0]), 1523);
            check("oversize_bad_bytes", 64'(frame_bad(0, 0)), 0);
            check("oversize_err_pos", 64'(err_at[0]), 64'(fr_start[0] + fr_len[0]));
        end

        // reset during payload byte 20 (42nd byte on the wire)
        start_test();
        add_words(1, 1'b1);
        drive_stream(2000);
        n = 0;
        for (int g = 0; g < 200 && n < 42; g++) begin
            @(negedge clk);
            #1;
            n = 0;
            foreach (log_q[i]) begin e = log_q[i]; if (e[8]) n++; end
        end
        check("rst_mid_reached", 64'(n), 42);
        rst = 1'b1;
        #1;
        check("rst_mid_outputs", {gmii_txd, gmii_tx_en, gmii_tx_er, s_ready, tx_busy, frame_done, frame_err}, 0);
        repeat (4) @(negedge clk);
        log_on = 1'b0;
        scan();
        check("rst_mid_done", 64'(done_at.size()), 0);
        check("rst_mid_err", 64'(err_at.size()), 0);
        check("rst_mid_cut_len", 64'(fr_len.size() == 1 ? fr_len[0] : -1), 42);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        start_test();
        add_words(1, 1'b1);
        model_frame(1, 1'b1);
        drive_stream(2000);
        wait_idle(2000);
        log_on = 1'b0;
        check_good("after_rst", 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/eth_tx_framer.md
ETH_TX_FRAMER -- requirements
Module: eth_tx_framer

Interface
REQ-001 SHALL have parameter LOCAL_MAC, default 48'h02_00_C0_A8_00_01, the source MAC address.
REQ-002 SHALL have parameter REMOTE_MAC, default 48'h02_00_C0_A8_00_02, the destination MAC address.
REQ-003 SHALL have parameter ETHERTYPE, default 16'h0800, the EtherType field.
REQ-004 SHALL have parameter IFG_CYCLES, default 12, the idle cycles after each frame (range 1..255).
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all logic rising-edge.
REQ-006 SHALL have port rst, input, 1 bit, the reset: asynchronous, active-high.
REQ-007 SHALL have port s_data, input, 32 bits, the payload word; bits 31:24 are sent first.
REQ-008 SHALL have ports s_valid (input, 1), s_ready (output, 1) and s_last (input, 1), the upstream handshake; s_last marks the final payload word.
REQ-009 SHALL have ports gmii_txd (output, 8), gmii_tx_en (output, 1) and gmii_tx_er (output, 1), the byte stream to the PHY.
REQ-010 SHALL have ports tx_busy (output, 1), frame_done (output, 1, pulse) and frame_err (output, 1, pulse), the status outputs.

Function
REQ-011 SHALL use states IDLE, PREAMBLE, HEADER, PAYLOAD, PAD, FCS, DROP and IFG.
REQ-012 SHALL leave IDLE for PREAMBLE on the cycle s_valid=1; gmii_tx_en SHALL rise one cycle later (all GMII outputs registered).
REQ-013 PREAMBLE SHALL emit 7 x 8'h55 then 8'hD5; HEADER SHALL emit REMOTE_MAC, then LOCAL_MAC, then ETHERTYPE, each MSB byte first (14 bytes).
REQ-014 A word SHALL transfer only when s_valid=1 and s_ready=1; s_ready SHALL be 1 only on the last HEADER byte cycle, and on the 4th byte cycle of a PAYLOAD word whose s_last was 0.
REQ-015 PAYLOAD SHALL emit the 4 bytes of each accepted word over 4 consecutive cycles; no idle byte cycles are allowed inside a frame.
REQ-016 Underrun (s_valid=0 when s_ready=1): gmii_tx_en=1 and gmii_tx_er=1 for one cycle with gmii_txd=8'h00, then frame_err pulses, and the block SHALL go to IFG without FCS.
REQ-017 After the s_last word, if fewer than 46 payload bytes were sent, PAD SHALL emit 8'h00 bytes until 46 payload bytes are reached.
REQ-018 A 16-bit payload byte counter SHALL track the payload; on the 1501st payload byte slot (word 376 present without s_last), the block SHALL assert gmii_tx_er for one cycle, pulse frame_err, then enter DROP.
REQ-019 DROP SHALL hold s_ready=1, discard words until an accepted word carries s_last, then go to IFG.
REQ-020 IFG SHALL hold gmii_tx_en=0 for exactly IFG_CYCLES cycles, then return to IDLE; a waiting s_valid is not acted on before IDLE.
REQ-021 frame_done SHALL pulse for 1 cycle on the cycle after the last byte of a good frame; frame_done and frame_err SHALL never pulse for the same frame.
REQ-022 tx_busy SHALL be 1 in every state except IDLE.
REQ-023 gmii_txd SHALL be 8'h00 whenever gmii_tx_en=0.

Reset
REQ-024 While rst=1 (asynchronous), the block SHALL drive gmii_txd=0, gmii_tx_en=0, gmii_tx_er=0, s_ready=0, tx_busy=0, frame_done=0 and frame_err=0, with state IDLE and all counters and the CRC cleared.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately with no FCS and no pulses; the first frame after reset release SHALL start from PREAMBLE.

Configuration
REQ-026 With macro ETH_TX_FRAMER_FCS_EN defined, the block SHALL compute the IEEE 802.3 CRC-32 over all bytes from the destination MAC through the pad.
REQ-027 The CRC SHALL be reflected poly 0xEDB88320, init 0xFFFFFFFF and final complement, and SHALL be sent in FCS as 4 bytes, least significant byte first.
REQ-028 Without ETH_TX_FRAMER_FCS_EN, the block SHALL contain no CRC logic; the frame SHALL end after the pad and frame_done SHALL follow the last pad or payload byte.

Verification
REQ-029 1 word 0xDEADBEEF with s_last, FCS_EN on -> tx_en high 72 cycles: 55x7, D5, header, DE AD BE EF, 42 x 00, FCS matching a software CRC model; then 12 idle cycles.
REQ-030 12 words (48 bytes) with FCS_EN on -> no pad, tx_en high 8+14+48+4 = 74 cycles, frame_done pulses once.
REQ-031 Frame of 5 words with s_valid dropped before word 3 -> one tx_er cycle after byte 8 of the payload, frame_err pulse, no FCS, then the IFG.
REQ-032 Two back-to-back 1-word frames (s_valid held) -> exactly IFG_CYCLES cycles of tx_en=0 between them, and both FCS values correct.
REQ-033 rst pulsed during payload byte 20 -> all outputs 0 in the same cycle; the next frame is a complete, correct 72-byte frame.
REQ-034 Same stimulus as REQ-029 with FCS_EN off -> tx_en high 68 cycles, and the last byte is the 42nd pad byte.
